clock_edge_monitor: RTL and testbench
=====================================

Name: clock_edge_monitor

Overview:
Receive-side companion to the board clock divider. Takes a slow toggling clock or strobe from another domain or pin, synchronises it into clk_in, and emits single-cycle rise/fall pulses. Measures the half-period in clk_in cycles and reports lock when consecutive intervals match the expected divider setting. Flags loss of lock so the ping-pong buffer control logic can stall or recover.

Parameters:
EXP_HALF_PERIOD, 25_000_000, expected clk_in cycles between successive edges (equals the divider's DIV_FACTOR)
TOL, 1024, allowed deviation in cycles; interval is good iff |interval - EXP_HALF_PERIOD| <= TOL
LOCK_COUNT, 4, consecutive good intervals required to assert locked
SYNC_STAGES, 2, synchroniser depth, minimum 2
(derived) MAX = EXP_HALF_PERIOD + TOL + 1; CW = $clog2(MAX+1)

Ports:
clk_in  input  1  system clock
rst  input  1  reset
sig_in  input  1  slow signal, asynchronous to clk_in
clear_lost  input  1  single-cycle clear of the lost flag
rise_pulse  output  1  one-cycle pulse per synchronised rising edge
fall_pulse  output  1  one-cycle pulse per synchronised falling edge
half_period  output  CW  last measured edge-to-edge interval in clk_in cycles
period_valid  output  1  one-cycle pulse when half_period updates
locked  output  1  interval stable within tolerance
lost  output  1  sticky: lock was lost since last clear

Behaviour:
- Reset rst, asynchronous, active-high; clock clk_in. On reset:
  - all outputs 0;
  - synchroniser flops, previous-sample flop, counter, good count all 0;
  - FSM to IDLE.
- Synchroniser: SYNC_STAGES flops.
  - An edge event fires when the last stage differs from its registered previous value.
  - rise_pulse/fall_pulse are registered, asserted for exactly one cycle.
  - Latency is SYNC_STAGES+1 clk_in edges from the first edge that samples the new sig_in level.
- Interval counter cnt (CW bits):
  - On an edge event: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at MAX.
  - An edge N cycles after the previous edge sees cnt == N.
- Measurement: on an edge event in ACQUIRE or LOCKED, half_period <= cnt and period_valid pulses, aligned with rise/fall_pulse.
  - Edges in IDLE do not update half_period or pulse period_valid; rise/fall pulses still fire.
- Timeout: cnt == MAX with no edge event, evaluated each cycle. While saturated, no period_valid is produced.
- FSM:
  - IDLE: edge event -> ACQUIRE, good_cnt=0.
  - ACQUIRE, edge event with good interval: good_cnt+1. When it reaches LOCK_COUNT -> LOCKED; locked=1 the cycle after that edge.
  - ACQUIRE, edge event with bad interval: good_cnt=0, stay in ACQUIRE.
  - ACQUIRE, timeout -> IDLE.
  - LOCKED, edge event with bad interval -> ACQUIRE with good_cnt=0, locked=0, lost=1.
  - LOCKED, timeout -> IDLE, locked=0, lost=1.
  - locked is high exactly while in LOCKED (registered).
- lost:
  - Set on leaving LOCKED; cleared by clear_lost.
  - Set and clear in the same cycle: set wins.
- Edge event coinciding with cnt at MAX: interval is bad by construction. The state is already IDLE after the timeout, so it counts as a first edge.
- Glitches shorter than a clk_in period may be missed. No filtering is required.
- Reset mid-operation: immediate return to reset values. The first edge after reset is never measured.

Test Plan:
Use EXP_HALF_PERIOD=8, TOL=1, LOCK_COUNT=3, SYNC_STAGES=2 (MAX=10).
1. Toggle sig_in every 8 cycles -> rise/fall pulses alternate, one cycle each, 3 cycles after the sample edge. period_valid from the 2nd edge with half_period=8. locked=1 the cycle after the 4th edge.
2. Toggle every 10 cycles -> half_period=10 each edge, locked stays 0, lost stays 0.
3. Locked, then one interval of 6, then intervals of 8 -> locked=0 and lost=1 after the bad edge. Relock after 3 further good edges. lost stays 1 until clear_lost pulses, then 0.
4. Locked, then sig_in held constant -> 10 cycles after the last edge locked=0 and lost=1, with no period_valid. Resume toggling every 8 -> relock after 1+3 edges.
5. clear_lost asserted in the same cycle as a loss event -> lost remains 1. A later clear_lost alone -> lost=0.
6. Assert rst asynchronously while LOCKED -> all outputs 0 immediately, without waiting for a clock edge. After release, the first edge gives no period_valid.

Source files
------------

// File: rtl/clock_edge_monitor.sv
// ---------------------------------------------------------------------------
// clock_edge_monitor
//
// Receive-side companion to the board clock divider. A slow toggling signal
// from another clock domain (or a pin) is synchronised into clk_in. Each
// synchronised edge produces a one-cycle rise or fall pulse. The distance
// between successive edges is measured in clk_in cycles and compared against
// the expected divider setting. A small FSM reports lock once enough
// consecutive intervals fall within tolerance. It also raises a sticky
// "lost" flag whenever an established lock is dropped.
//
// Ports:
//   clk_in        system clock
//   rst           asynchronous, active-high reset
//   sig_in        slow signal, asynchronous to clk_in
//   clear_lost    single-cycle clear of the sticky lost flag
//   rise_pulse    one-cycle pulse per synchronised rising edge
//   fall_pulse    one-cycle pulse per synchronised falling edge
//   half_period   last measured edge-to-edge interval in clk_in cycles
//   period_valid  one-cycle pulse when half_period updates
//   locked        high while the interval is stable within tolerance
//   lost          sticky: lock was lost since the last clear
// ---------------------------------------------------------------------------
module clock_edge_monitor #(
    parameter int EXP_HALF_PERIOD = 25_000_000,
    parameter int TOL             = 1024,
    parameter int LOCK_COUNT      = 4,
    parameter int SYNC_STAGES     = 2,
    localparam int MAX            = EXP_HALF_PERIOD + TOL + 1,
    localparam int CW             = $clog2(MAX + 1)
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          sig_in,
    input  logic          clear_lost,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic [CW-1:0] half_period,
    output logic          period_valid,
    output logic          locked,
    output logic          lost
);

    localparam int GW = $clog2(LOCK_COUNT + 1);

    localparam logic [CW-1:0] MAX_C  = CW'(MAX);
    localparam logic [CW-1:0] LO_C   = CW'((EXP_HALF_PERIOD > TOL) ? (EXP_HALF_PERIOD - TOL) : 0);
    localparam logic [CW-1:0] HI_C   = CW'(EXP_HALF_PERIOD + TOL);
    localparam logic [GW-1:0] LAST_G = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   prev_ff;
    logic [CW-1:0]          cnt;
    logic [GW-1:0]          good_cnt;

    logic sync_last;
    logic edge_evt;
    logic timeout;
    logic good_interval;
    logic lose_lock;

    assign sync_last = sync_ff[SYNC_STAGES-1];
    assign edge_evt  = sync_last ^ prev_ff;

    // The counter saturates at MAX. Sitting at MAX without a new edge means
    // the source has stopped toggling. An edge that lands exactly when cnt
    // reaches MAX is still measured, and it is out of tolerance by construction.
    assign timeout       = (cnt == MAX_C) && !edge_evt;
    assign good_interval = (cnt >= LO_C) && (cnt <= HI_C);

    // A lock is lost either by a bad interval or by the source going silent.
    assign lose_lock = (state == LOCKED) && ((edge_evt && !good_interval) || timeout);

    // Synchroniser, edge pulses, interval counter, lock FSM and sticky lost
    // flag all share one register block so that every output is registered
    // and lines up on the same clock edge as the rise/fall pulse.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sync_ff      <= '0;
            prev_ff      <= 1'b0;
            cnt          <= '0;
            good_cnt     <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            sync_ff    <= {sync_ff[SYNC_STAGES-2:0], sig_in};
            prev_ff    <= sync_last;
            rise_pulse <= edge_evt & sync_last;
            fall_pulse <= edge_evt & ~sync_last;

            if (edge_evt) begin
                cnt <= CW'(1);
            end else if (cnt != MAX_C) begin
                cnt <= cnt + 1'b1;
            end

            // A new loss outranks a simultaneous clear so the event is never hidden.
            if (lose_lock) begin
                lost <= 1'b1;
            end else if (clear_lost) begin
                lost <= 1'b0;
            end

            period_valid <= 1'b0;

            case (state)
                IDLE: begin
                    // The first edge only starts the timing reference.
                    if (edge_evt) begin
                        state    <= ACQUIRE;
                        good_cnt <= '0;
                    end
                end

                ACQUIRE: begin
                    if (edge_evt) begin
                        half_period  <= cnt;
                        period_valid <= 1'b1;
                        if (good_interval) begin
                            if (good_cnt == LAST_G) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                good_cnt <= '0;
                            end else begin
                                good_cnt <= good_cnt + 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state    <= IDLE;
                        good_cnt <= '0;
                    end
                end

                LOCKED: begin
                    if (edge_evt) begin
                        half_period  <= cnt;
                        period_valid <= 1'b1;
                        if (!good_interval) begin
                            state    <= ACQUIRE;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    locked   <= 1'b0;
                    good_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_edge_monitor.sv
// ---------------------------------------------------------------------------
// tb_clock_edge_monitor
//
// Directed bench for clock_edge_monitor with EXP_HALF_PERIOD=8, TOL=1,
// LOCK_COUNT=3 and SYNC_STAGES=2, so MAX=10 and half_period is 4 bits wide.
// Each call to applyStimulus toggles sig_in and then waits a given number of
// clk_in cycles. It watches the outputs after every cycle. The interval
// measured at an edge therefore equals the gap of the previous call. All
// expected values are written out by hand in the calls below.
// ---------------------------------------------------------------------------
module tb_clock_edge_monitor;

    logic       clk_in;
    logic       rst;
    logic       sig_in;
    logic       clear_lost;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [3:0] half_period;
    logic       period_valid;
    logic       locked;
    logic       lost;

    int checks = 0;
    int errors = 0;

    clock_edge_monitor #(
        .EXP_HALF_PERIOD(8),
        .TOL(1),
        .LOCK_COUNT(3),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .sig_in(sig_in),
        .clear_lost(clear_lost),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .half_period(half_period),
        .period_valid(period_valid),
        .locked(locked),
        .lost(lost)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // A runaway simulation is reported and then stopped hard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the active edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic doReset();
        rst        = 1'b1;
        sig_in     = 1'b0;
        clear_lost = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (12) tick();
    endtask

    // Toggle sig_in, then watch for gap cycles. The pulse must appear on tick 3.
    // exp_change is the tick at which locked first differs from its value
    // before the toggle (0 = no change). clear_at raises clear_lost after that
    // tick for one cycle (0 = none).
    task automatic applyStimulus(input string tag, input int gap, input int exp_pv,
                                 input int exp_hp, input int exp_locked,
                                 input int exp_lost, input int exp_change,
                                 input int clear_at);
        int   rise_cnt;
        int   fall_cnt;
        int   pulse_tick;
        int   pv_cnt;
        int   last_hp;
        int   change_tick;
        logic start_locked;
        logic new_val;

        rise_cnt     = 0;
        fall_cnt     = 0;
        pulse_tick   = 0;
        pv_cnt       = 0;
        last_hp      = 0;
        change_tick  = 0;
        start_locked = locked;
        new_val      = ~sig_in;
        sig_in       = new_val;

        for (int t = 1; t <= gap; t++) begin
            tick();
            clear_lost = (t == clear_at);
            if (rise_pulse) begin
                rise_cnt++;
                pulse_tick = t;
            end
            if (fall_pulse) begin
                fall_cnt++;
                pulse_tick = t;
            end
            if (period_valid) begin
                pv_cnt++;
                last_hp = int'(half_period);
            end
            if (change_tick == 0 && locked != start_locked) begin
                change_tick = t;
            end
        end
        clear_lost = 1'b0;

        checkOutput({tag, " rise"}, rise_cnt, new_val ? 1 : 0);
        checkOutput({tag, " fall"}, fall_cnt, new_val ? 0 : 1);
        checkOutput({tag, " pulse_tick"}, pulse_tick, 3);
        checkOutput({tag, " pv_count"}, pv_cnt, exp_pv);
        if (exp_pv != 0) begin
            checkOutput({tag, " half_period"}, last_hp, exp_hp);
        end
        checkOutput({tag, " locked"}, int'(locked), exp_locked);
        checkOutput({tag, " lost"}, int'(lost), exp_lost);
        checkOutput({tag, " lock_change_tick"}, change_tick, exp_change);
    endtask

    initial begin
        rst        = 1'b1;
        sig_in     = 1'b0;
        clear_lost = 1'b0;
        #2;

        // Reset values
        checkOutput("reset rise", int'(rise_pulse), 0);
        checkOutput("reset fall", int'(fall_pulse), 0);
        checkOutput("reset half_period", int'(half_period), 0);
        checkOutput("reset pv", int'(period_valid), 0);
        checkOutput("reset locked", int'(locked), 0);
        checkOutput("reset lost", int'(lost), 0);

        // Intervals of 10 (= MAX) are out of tolerance: measured but never locked
        doReset();
        applyStimulus("t2e1", 10, 0, 0, 0, 0, 0, 0);
        applyStimulus("t2e2", 10, 1, 10, 0, 0, 0, 0);
        applyStimulus("t2e3", 10, 1, 10, 0, 0, 0, 0);
        applyStimulus("t2e4", 10, 1, 10, 0, 0, 0, 0);
        applyStimulus("t2e5", 10, 1, 10, 0, 0, 0, 0);

        // Nominal toggling, lock after the 4th edge
        doReset();
        applyStimulus("t1e1", 8, 0, 0, 0, 0, 0, 0);
        applyStimulus("t1e2", 8, 1, 8, 0, 0, 0, 0);
        applyStimulus("t1e3", 8, 1, 8, 0, 0, 0, 0);
        applyStimulus("t1e4", 8, 1, 8, 1, 0, 3, 0);
        applyStimulus("t1e5", 8, 1, 8, 1, 0, 0, 0);

        // One short interval of 6 drops lock, three good edges relock, then clear
        applyStimulus("t3e6", 6, 1, 8, 1, 0, 0, 0);
        applyStimulus("t3e7", 8, 1, 6, 0, 1, 3, 0);
        applyStimulus("t3e8", 8, 1, 8, 0, 1, 0, 0);
        applyStimulus("t3e9", 8, 1, 8, 0, 1, 0, 0);
        applyStimulus("t3e10", 8, 1, 8, 1, 0, 3, 6);

        // Source stops: timeout 10 cycles after the edge, then relock after 1+3
        applyStimulus("t4e11", 20, 1, 8, 0, 1, 13, 0);
        applyStimulus("t4e12", 8, 0, 0, 0, 1, 0, 0);
        applyStimulus("t4e13", 8, 1, 8, 0, 1, 0, 0);
        applyStimulus("t4e14", 8, 1, 8, 0, 1, 0, 0);
        applyStimulus("t4e15", 6, 1, 8, 1, 0, 3, 5);

        // Clear in the same cycle as a loss: set wins; a later lone clear works
        applyStimulus("t5e16", 8, 1, 6, 0, 1, 3, 2);
        clear_lost = 1'b1;
        tick();
        clear_lost = 1'b0;
        checkOutput("t5 lone clear lost", int'(lost), 0);

        // Asynchronous reset while locked
        doReset();
        applyStimulus("t6e1", 8, 0, 0, 0, 0, 0, 0);
        applyStimulus("t6e2", 8, 1, 8, 0, 0, 0, 0);
        applyStimulus("t6e3", 8, 1, 8, 0, 0, 0, 0);
        applyStimulus("t6e4", 8, 1, 8, 1, 0, 3, 0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("t6 async locked", int'(locked), 0);
        checkOutput("t6 async half_period", int'(half_period), 0);
        checkOutput("t6 async pv", int'(period_valid), 0);
        checkOutput("t6 async lost", int'(lost), 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        applyStimulus("t6e5", 8, 0, 0, 0, 0, 0, 0);
        applyStimulus("t6e6", 8, 1, 8, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
